// File: rtl/alu_cla_pipe_pkg.sv
// rtl/alu_cla_pipe_pkg.sv - shared select constants and group size for the pipelined CLA ALU
package alu_pkg;

    // Arithmetic mode: s[1:0] picks the B-side operand.
    localparam logic [1:0] ARITH_B    = 2'b00;
    localparam logic [1:0] ARITH_NB   = 2'b01;
    localparam logic [1:0] ARITH_ZERO = 2'b10;
    localparam logic [1:0] ARITH_ONES = 2'b11;

    // Logic mode: s[1:0] picks the bitwise function.
    localparam logic [1:0] LOGIC_AND  = 2'b00;
    localparam logic [1:0] LOGIC_OR   = 2'b01;
    localparam logic [1:0] LOGIC_XOR  = 2'b10;
    localparam logic [1:0] LOGIC_NOTA = 2'b11;

    // Bits per lookahead group.
    localparam int GROUP = 4;

endpackage

// File: rtl/alu_cla_pipe_if.sv
// rtl/alu_cla_pipe_if.sv - operand/result handshake bundle for alu_cla_pipe
// master: operand source / result sink (drives in_*, a, b, s, m, cin, out_ready)
// slave : the ALU (drives in_ready, out_valid, f, cout, ovf, zero, gp, gg)
interface alu_cla_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             gp;
    logic             gg;

    modport master (
        output in_valid, a, b, s, m, cin, out_ready,
        input  in_ready, out_valid, f, cout, ovf, zero, gp, gg
    );

    modport slave (
        input  in_valid, a, b, s, m, cin, out_ready,
        output in_ready, out_valid, f, cout, ovf, zero, gp, gg
    );
endinterface

// File: rtl/alu_cla_pipe_cla_group4.sv
// rtl/alu_cla_pipe_cla_group4.sv - 4-bit carry lookahead group
// p, g : per-bit propagate/generate   c_in : carry into bit 0
// c    : carries into bits 0..3       P, G : group propagate/generate
module cla_group4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       c_in,
    output logic [3:0] c,
    output logic       P,
    output logic       G
);
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);

    assign P = &p;
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/alu_cla_pipe.sv
// rtl/alu_cla_pipe.sv - two-stage pipelined CLA ALU with valid/ready on both sides
// clk, rst_n : clock, asynchronous active-low reset
// bus        : slave side of alu_cla_pipe_if (operands in, result + flags out)
module alu_cla_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_cla_pipe_if.slave bus
);
    localparam int NGRP = WIDTH / GROUP;

    // Handshake
    logic s1_valid_q;
    logic out_valid_q;
    logic s1_adv;
    logic s2_adv;
    logic in_fire;
    logic s2_load;

    assign s2_adv       = ~out_valid_q | bus.out_ready;
    assign s1_adv       = ~s1_valid_q | s2_adv;
    assign bus.in_ready = s1_adv;
    assign in_fire      = bus.in_valid & s1_adv;
    assign s2_load      = s2_adv & s1_valid_q;

    // Stage 1: operand selection, per-bit p/g, logic result
    logic [WIDTH-1:0] a_op, b_op;
    logic [WIDTH-1:0] p_d, g_d, lres_d;
    logic [WIDTH-1:0] p_q, g_q, lres_q;
    logic             m_q, cin_q;

    always_comb begin
        a_op = bus.s[2] ? '0 : bus.a;
        case (bus.s[1:0])
            ARITH_B:    b_op = bus.b;
            ARITH_NB:   b_op = ~bus.b;
            ARITH_ZERO: b_op = '0;
            default:    b_op = '1;
        endcase
        p_d = a_op ^ b_op;
        g_d = a_op & b_op;
        case (bus.s[1:0])
            LOGIC_AND:  lres_d = bus.a & bus.b;
            LOGIC_OR:   lres_d = bus.a | bus.b;
            LOGIC_XOR:  lres_d = bus.a ^ bus.b;
            default:    lres_d = ~bus.a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            lres_q     <= '0;
            m_q        <= 1'b0;
            cin_q      <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= bus.in_valid;
            if (in_fire) begin
                p_q    <= p_d;
                g_q    <= g_d;
                lres_q <= lres_d;
                m_q    <= bus.m;
                cin_q  <= bus.cin;
            end
        end
    end

    // Stage 2: lookahead within groups, group P/G rippled across groups.
    // gcar carries the real cin; ggen is the same ripple seeded with 0 so
    // that gg reflects the whole-word generate independent of cin.
    logic [WIDTH:0] c;
    logic [NGRP:0]  gcar;
    logic [NGRP:0]  ggen;

    assign gcar[0] = cin_q;
    assign ggen[0] = 1'b0;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic grp_p, grp_g;
        cla_group4 u_grp (
            .p    (p_q[k*GROUP +: GROUP]),
            .g    (g_q[k*GROUP +: GROUP]),
            .c_in (gcar[k]),
            .c    (c[k*GROUP +: GROUP]),
            .P    (grp_p),
            .G    (grp_g)
        );
        assign gcar[k+1] = grp_g | (grp_p & gcar[k]);
        assign ggen[k+1] = grp_g | (grp_p & ggen[k]);
    end

    assign c[WIDTH] = gcar[NGRP];

    logic [WIDTH-1:0] f_d, f_q;
    logic             cout_d, ovf_d, zero_d, gp_d, gg_d;
    logic             cout_q, ovf_q, zero_q, gp_q, gg_q;

    always_comb begin
        f_d    = m_q ? lres_q : (p_q ^ c[WIDTH-1:0]);
        cout_d = ~m_q & c[WIDTH];
        ovf_d  = ~m_q & (c[WIDTH] ^ c[WIDTH-1]);
        gp_d   = ~m_q & (&p_q);
        gg_d   = ~m_q & ggen[NGRP];
        zero_d = ~|f_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            gp_q        <= 1'b0;
            gg_q        <= 1'b0;
        end else begin
            if (s2_adv) out_valid_q <= s1_valid_q;
            if (s2_load) begin
                f_q    <= f_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                gp_q   <= gp_d;
                gg_q   <= gg_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.gp        = gp_q;
    assign bus.gg        = gg_q;

endmodule
